// File: rtl/uart_link_core.sv
// rtl/uart_link_core.sv - UART link with TX/RX FIFOs, serialiser and mid-bit-sampling deserialiser
// Frames: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; errors are sticky until err_clr.
module uart_link_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_wr_en,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_full,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        tx,
  output logic                        tx_busy,
  input  logic                        rx,
  input  logic                        rx_rd_en,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_empty,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        rx_busy,
  input  logic                        err_clr,
  output logic                        err_frame,
  output logic                        err_parity,
  output logic                        err_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] txf_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        txf_wr_q, txf_rd_q;
  logic [LW-1:0]        txf_lvl_q;
  logic                 txf_push, txf_pop, txf_empty;
  logic [DATA_BITS-1:0] txf_head;

  assign tx_full   = (txf_lvl_q == FULL_LVL);
  assign tx_level  = txf_lvl_q;
  assign txf_empty = (txf_lvl_q == '0);
  assign txf_push  = tx_wr_en && !tx_full;
  assign txf_head  = txf_mem_q[txf_rd_q];

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem_q[txf_wr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txf_wr_q  <= '0;
      txf_rd_q  <= '0;
      txf_lvl_q <= '0;
    end else begin
      if (txf_push) txf_wr_q <= txf_wr_q + 1'b1;
      if (txf_pop)  txf_rd_q <= txf_rd_q + 1'b1;
      txf_lvl_q <= txf_lvl_q + LW'(txf_push) - LW'(txf_pop);
    end
  end

  // ---------------- TX serialiser ----------------
  state_t               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    txf_pop    = 1'b0;
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_cnt_q + 1'b1;
    case (tx_state_q)
      S_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 1'b1;
        if (tx_bit_q == DATA_LAST) begin
          tx_bit_d   = '0;
          tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = S_STOP;
      end
      S_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == STOP_LAST) begin
          tx_bit_d   = '0;
          tx_state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    // Load from the FIFO in IDLE or straight out of the last stop bit: no gap between frames.
    if (!txf_empty && (tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_state_d == S_IDLE))) begin
      txf_pop    = 1'b1;
      tx_shift_d = txf_head;
      tx_par_d   = (^txf_head) ^ ODD;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_state_d = S_START;
    end
  end

  assign tx_busy = (tx_state_q != S_IDLE);
  assign tx = (tx_state_q == S_START)  ? 1'b0 :
              (tx_state_q == S_DATA)   ? tx_shift_q[0] :
              (tx_state_q == S_PARITY) ? tx_par_q : 1'b1;

  // ---------------- RX deserialiser ----------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  state_t               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_pbad_q, rx_pbad_d;
  logic                 rx_good, set_frame, set_parity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pbad_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbad_q  <= rx_pbad_d;
    end
  end

  // The counter runs down; each state acts when it reaches zero (mid-bit).
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbad_d  = rx_pbad_q;
    rx_good    = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
    if (rx_state_q != S_IDLE && rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = HALF_LAST;
          rx_pbad_d  = 1'b0;
        end
        S_START: begin
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          rx_cnt_d   = BIT_LAST;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == DATA_LAST) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          rx_cnt_d   = BIT_LAST;
          rx_pbad_d  = rx_sync_q != ((^rx_shift_q) ^ ODD);
          rx_state_d = S_STOP;
        end
        S_STOP: begin
          rx_state_d = S_IDLE;
          if (!rx_sync_q)     set_frame  = 1'b1;
          else if (rx_pbad_q) set_parity = 1'b1;
          else                rx_good    = 1'b1;
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  assign rx_busy = (rx_state_q != S_IDLE);

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rxf_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rxf_wr_q, rxf_rd_q;
  logic [LW-1:0]        rxf_lvl_q;
  logic                 rxf_push, rxf_pop, rxf_full, set_overrun;

  assign rxf_full    = (rxf_lvl_q == FULL_LVL);
  assign rx_empty    = (rxf_lvl_q == '0);
  assign rx_level    = rxf_lvl_q;
  assign rxf_pop     = rx_rd_en && !rx_empty;
  assign rxf_push    = rx_good && (!rxf_full || rxf_pop);
  assign set_overrun = rx_good && rxf_full && !rxf_pop;
  assign rx_data     = rx_empty ? '0 : rxf_mem_q[rxf_rd_q];

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem_q[rxf_wr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxf_wr_q    <= '0;
      rxf_rd_q    <= '0;
      rxf_lvl_q   <= '0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (rxf_push) rxf_wr_q <= rxf_wr_q + 1'b1;
      if (rxf_pop)  rxf_rd_q <= rxf_rd_q + 1'b1;
      rxf_lvl_q   <= rxf_lvl_q + LW'(rxf_push) - LW'(rxf_pop);
      err_frame   <= (err_frame   && !err_clr) || set_frame;
      err_parity  <= (err_parity  && !err_clr) || set_parity;
      err_overrun <= (err_overrun && !err_clr) || set_overrun;
    end
  end

endmodule

// File: tb/tb_uart_link_core.sv
// tb/tb_uart_link_core.sv - directed bench for uart_link_core (loopback, FIFO limits, error flags, reset)
module tb_uart_link_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, err_clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instance A: no parity, 1 stop bit, optional loopback.
  logic       loop_a, rx_drv_a, rx_a, tx_wr_en_a, rx_rd_en_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic [2:0] tx_level_a, rx_level_a;
  logic       tx_full_a, tx_a, tx_busy_a, rx_empty_a, rx_busy_a;
  logic       err_frame_a, err_parity_a, err_overrun_a;
  assign rx_a = loop_a ? tx_a : rx_drv_a;

  // Instance B: even parity.
  logic       rx_drv_b, tx_wr_en_b, rx_rd_en_b;
  logic [7:0] tx_data_b, rx_data_b;
  logic [2:0] tx_level_b, rx_level_b;
  logic       tx_full_b, tx_b, tx_busy_b, rx_empty_b, rx_busy_b;
  logic       err_frame_b, err_parity_b, err_overrun_b;

  // Instance C: 9 data bits, 2 stop bits.
  logic       rx_drv_c, tx_wr_en_c, rx_rd_en_c;
  logic [8:0] tx_data_c, rx_data_c;
  logic [2:0] tx_level_c, rx_level_c;
  logic       tx_full_c, tx_c, tx_busy_c, rx_empty_c, rx_busy_c;
  logic       err_frame_c, err_parity_c, err_overrun_c;

  uart_link_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_wr_en(tx_wr_en_a), .tx_data(tx_data_a), .tx_full(tx_full_a),
    .tx_level(tx_level_a), .tx(tx_a), .tx_busy(tx_busy_a), .rx(rx_a), .rx_rd_en(rx_rd_en_a),
    .rx_data(rx_data_a), .rx_empty(rx_empty_a), .rx_level(rx_level_a), .rx_busy(rx_busy_a),
    .err_clr(err_clr), .err_frame(err_frame_a), .err_parity(err_parity_a), .err_overrun(err_overrun_a));

  uart_link_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_wr_en(tx_wr_en_b), .tx_data(tx_data_b), .tx_full(tx_full_b),
    .tx_level(tx_level_b), .tx(tx_b), .tx_busy(tx_busy_b), .rx(rx_drv_b), .rx_rd_en(rx_rd_en_b),
    .rx_data(rx_data_b), .rx_empty(rx_empty_b), .rx_level(rx_level_b), .rx_busy(rx_busy_b),
    .err_clr(err_clr), .err_frame(err_frame_b), .err_parity(err_parity_b), .err_overrun(err_overrun_b));

  uart_link_core #(.CLKS_PER_BIT(4), .DATA_BITS(9), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_wr_en(tx_wr_en_c), .tx_data(tx_data_c), .tx_full(tx_full_c),
    .tx_level(tx_level_c), .tx(tx_c), .tx_busy(tx_busy_c), .rx(rx_drv_c), .rx_rd_en(rx_rd_en_c),
    .rx_data(rx_data_c), .rx_empty(rx_empty_c), .rx_level(rx_level_c), .rx_busy(rx_busy_c),
    .err_clr(err_clr), .err_frame(err_frame_c), .err_parity(err_parity_c), .err_overrun(err_overrun_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_drv_b = v;
    else     rx_drv_a = v;
  endtask

  // Drives one frame, 4 cycles per bit; returns 4 cycles after the stop bit began.
  task automatic send_frame(input bit sel, input logic [8:0] d, input int nb,
                            input bit has_par, input bit pb, input bit sb);
    drive(sel, 1'b0); tick(4);
    for (int i = 0; i < nb; i++) begin drive(sel, d[i]); tick(4); end
    if (has_par) begin drive(sel, pb); tick(4); end
    drive(sel, sb); tick(4);
  endtask

  initial begin
    logic [7:0] lb_bytes [2];
    logic [9:0] fr;
    logic [7:0] exp_words [4];
    int         cyc, busy_cnt, low_cnt;

    rst_n = 1'b0; err_clr = 1'b0; loop_a = 1'b1;
    rx_drv_a = 1'b1; rx_drv_b = 1'b1; rx_drv_c = 1'b1;
    tx_wr_en_a = 1'b0; tx_wr_en_b = 1'b0; tx_wr_en_c = 1'b0;
    rx_rd_en_a = 1'b0; rx_rd_en_b = 1'b0; rx_rd_en_c = 1'b0;
    tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
    tick(3);
    check_eq("rst_tx_line", {31'd0, tx_a}, 32'd1);
    check_eq("rst_busy", {30'd0, tx_busy_a, rx_busy_a}, 32'd0);
    check_eq("rst_errs", {29'd0, err_frame_a, err_parity_a, err_overrun_a}, 32'd0);
    check_eq("rst_fifos", {tx_full_a, tx_level_a, rx_level_a, rx_empty_a, rx_data_a}, 32'h100);
    rst_n = 1'b1;
    tick(2);

    // Loopback of 0xA5 then 0x3C.
    lb_bytes[0] = 8'hA5; lb_bytes[1] = 8'h3C;
    tx_wr_en_a = 1'b1; tx_data_a = 8'hA5; tick(1);
    tx_data_a = 8'h3C; tick(1);
    tx_wr_en_a = 1'b0;
    check_eq("lb_tx_level", {29'd0, tx_level_a}, 32'd1);
    check_eq("lb_tx_busy", {31'd0, tx_busy_a}, 32'd1);
    tick(1);
    for (int f = 0; f < 2; f++) begin
      fr = {1'b1, lb_bytes[f], 1'b0};
      for (int j = 0; j < 10; j++) begin
        check_eq($sformatf("lb_line_f%0d_b%0d", f, j), {31'd0, tx_a}, {31'd0, fr[j]});
        tick(4);
      end
    end
    tick(8);
    check_eq("lb_rx_level", {29'd0, rx_level_a}, 32'd2);
    check_eq("lb_rx_head0", {24'd0, rx_data_a}, 32'hA5);
    check_eq("lb_errs", {29'd0, err_frame_a, err_parity_a, err_overrun_a}, 32'd0);
    rx_rd_en_a = 1'b1; tick(1); rx_rd_en_a = 1'b0;
    check_eq("lb_rx_head1", {24'd0, rx_data_a}, 32'h3C);
    rx_rd_en_a = 1'b1; tick(1); rx_rd_en_a = 1'b0;
    check_eq("lb_rx_drained", {23'd0, rx_empty_a, rx_data_a}, 32'h100);

    // TX full while a frame is in flight, then RX overrun on the looped-back words.
    tx_wr_en_a = 1'b1; tx_data_a = 8'hFF; tick(1);
    for (int k = 1; k <= 4; k++) begin tx_data_a = 8'(k); tick(1); end
    check_eq("txfull_flag", {31'd0, tx_full_a}, 32'd1);
    check_eq("txfull_level", {29'd0, tx_level_a}, 32'd4);
    tx_data_a = 8'h05; tick(1);
    tx_wr_en_a = 1'b0;
    check_eq("txfull_drop_level", {29'd0, tx_level_a}, 32'd4);
    tick(260);
    check_eq("ovr_tx_idle", {27'd0, tx_busy_a, tx_full_a, tx_level_a}, 32'd0);
    check_eq("ovr_rx_level", {29'd0, rx_level_a}, 32'd4);
    check_eq("ovr_flag", {31'd0, err_overrun_a}, 32'd1);
    exp_words[0] = 8'hFF; exp_words[1] = 8'h01; exp_words[2] = 8'h02; exp_words[3] = 8'h03;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("ovr_word%0d", k), {24'd0, rx_data_a}, {24'd0, exp_words[k]});
      rx_rd_en_a = 1'b1; tick(1); rx_rd_en_a = 1'b0;
    end
    tick(60);
    check_eq("ovr_no_0x05", {31'd0, rx_empty_a}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check_eq("ovr_clr", {31'd0, err_overrun_a}, 32'd0);

    // Fifth word arrives while full but with a pop in the same cycle.
    loop_a = 1'b0; rx_drv_a = 1'b1; tick(2);
    for (int k = 0; k < 4; k++) begin send_frame(1'b0, 9'(8'h11 + k), 8, 1'b0, 1'b0, 1'b1); tick(2); end
    send_frame(1'b0, 9'h15, 8, 1'b0, 1'b0, 1'b1);
    rx_rd_en_a = 1'b1; tick(1); rx_rd_en_a = 1'b0;
    check_eq("pp_level", {29'd0, rx_level_a}, 32'd4);
    check_eq("pp_no_overrun", {31'd0, err_overrun_a}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("pp_word%0d", k), {24'd0, rx_data_a}, 32'h12 + 32'(k));
      rx_rd_en_a = 1'b1; tick(1); rx_rd_en_a = 1'b0;
    end

    // Frame error: stop bit low.
    send_frame(1'b0, 9'h55, 8, 1'b0, 1'b0, 1'b0);
    rx_drv_a = 1'b1; tick(3);
    check_eq("ferr_flags", {29'd0, err_frame_a, err_parity_a, err_overrun_a}, 32'd4);
    check_eq("ferr_discard", {31'd0, rx_empty_a}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check_eq("ferr_clr", {31'd0, err_frame_a}, 32'd0);

    // One-cycle glitch: detected, rejected at the start sample.
    rx_drv_a = 1'b0; tick(1); rx_drv_a = 1'b1; tick(2);
    check_eq("glitch_detect", {31'd0, rx_busy_a}, 32'd1);
    tick(5);
    check_eq("glitch_reject", {27'd0, rx_busy_a, rx_empty_a, err_frame_a, err_parity_a, err_overrun_a}, 32'h08);

    // Even parity on instance B.
    send_frame(1'b1, 9'h07, 8, 1'b1, 1'b0, 1'b1); tick(3);
    check_eq("par_bad_flags", {29'd0, err_frame_b, err_parity_b, rx_empty_b}, 32'd3);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check_eq("par_clr", {31'd0, err_parity_b}, 32'd0);
    send_frame(1'b1, 9'h07, 8, 1'b1, 1'b1, 1'b1); tick(3);
    check_eq("par_good_word", {23'd0, err_parity_b, rx_data_b}, 32'h07);
    check_eq("b_state", {20'd0, rx_busy_b, tx_full_b, tx_level_b, tx_b, tx_busy_b, err_frame_b, err_overrun_b, rx_level_b}, 32'h41);

    // Reset during data bit 3.
    tx_wr_en_a = 1'b1; tx_data_a = 8'h55; tick(1);
    tx_data_a = 8'h66; tick(1);
    tx_wr_en_a = 1'b0;
    tick(16);
    check_eq("mid_busy", {31'd0, tx_busy_a}, 32'd1);
    rst_n = 1'b0; tick(1);
    check_eq("mid_rst_line", {30'd0, tx_a, tx_busy_a}, 32'd2);
    check_eq("mid_rst_levels", {26'd0, tx_level_a, rx_level_a}, 32'd0);
    rst_n = 1'b1; tick(2);

    // 9 data bits + 2 stop bits: 12 bit times of 4 cycles, low only during start.
    tx_wr_en_c = 1'b1; tx_data_c = 9'h1FF; tick(1); tx_wr_en_c = 1'b0;
    cyc = 0;
    while (!tx_busy_c && cyc < 10) begin tick(1); cyc++; end
    check_eq("c_start_seen", {31'd0, tx_busy_c}, 32'd1);
    busy_cnt = 0; low_cnt = 0;
    while (tx_busy_c && busy_cnt < 200) begin
      if (!tx_c) low_cnt++;
      busy_cnt++;
      tick(1);
    end
    check_eq("c_frame_cycles", 32'(busy_cnt), 32'd48);
    check_eq("c_low_cycles", 32'(low_cnt), 32'd4);
    check_eq("c_idle", {11'd0, tx_full_c, tx_level_c, rx_level_c, rx_data_c, rx_empty_c, rx_busy_c,
                        err_frame_c, err_parity_c, err_overrun_c}, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_link_core.md
Name: uart_link_core

Overview:
- Self-contained, parametrised UART link: TX FIFO, serialiser, deserialiser with mid-bit sampling, and RX FIFO in one block.
- Adds configurable data width, FIFO depth, baud divisor, parity and stop bits, plus sticky frame, parity and overrun error reporting.
- Sits between the button/parser logic and the board serial pins, replacing discrete sender/receiver/fifo_buffer instances at the top level.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit; minimum 4.
- DATA_BITS, 8, payload bits per frame; range 5..9.
- FIFO_DEPTH, 16, entries per FIFO; power of two, ≥2.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted; 1 or 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- tx_wr_en  in  1  push tx_data into TX FIFO.
- tx_data  in  DATA_BITS  word to send.
- tx_full  out  1  TX FIFO full.
- tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  serialiser is mid-frame.
- rx  in  1  asynchronous serial input.
- rx_rd_en  in  1  pop RX FIFO head.
- rx_data  out  DATA_BITS  RX FIFO head, first-word-fall-through.
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- rx_busy  out  1  deserialiser is mid-frame.
- err_clr  in  1  clear all sticky error flags.
- err_frame  out  1  sticky: stop bit sampled low.
- err_parity  out  1  sticky: parity mismatch.
- err_overrun  out  1  sticky: good word dropped because RX FIFO full.

Behaviour:
- Reset (rst_n=0 at edge):
  - tx=1; tx_busy=0; rx_busy=0; all err_* flags=0.
  - Both FIFOs empty: levels 0, tx_full=0, rx_empty=1, rx_data=0.
  - Reset mid-frame aborts the frame immediately; tx is high on the next edge.
- TX FIFO:
  - Push when tx_wr_en && !tx_full; a push while full is dropped silently.
  - Pointers wrap modulo FIFO_DEPTH.
  - Level reflects a push on the following edge.
- TX FSM (IDLE → START → DATA → PARITY → STOP → IDLE):
  - In IDLE with FIFO non-empty: pop head, latch it into the shift register, enter START.
  - tx=0 and tx_busy=1 from the edge after the pop.
  - Each state lasts CLKS_PER_BIT cycles.
  - DATA sends DATA_BITS bits, LSB first.
  - PARITY is skipped when PARITY=0. Odd: XOR(data)^1. Even: XOR(data).
  - STOP holds tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - STOP→IDLE, and IDLE pops the next word the same cycle, so back-to-back frames have no extra idle bit.
- RX front end:
  - rx passes through a 2-flop synchroniser; latency 2 cycles counts against detection.
  - Start is detected on a synchronised 1→0 transition in IDLE only.
- RX FSM (IDLE → START → DATA → PARITY → STOP → IDLE):
  - On detection: rx_busy=1, counter loaded.
  - Start bit sampled at CLKS_PER_BIT/2 (integer divide). If high, it is a false start: return to IDLE, rx_busy=0, no flags set.
  - Subsequent samples are spaced CLKS_PER_BIT apart (mid-bit). Data is assembled LSB first.
  - Parity is checked when PARITY≠0.
  - Only the first stop bit is checked, regardless of STOP_BITS.
  - After the stop sample: return to IDLE, rx_busy=0, and one of:
    - stop=0: set err_frame, discard word.
    - parity bad (stop=1): set err_parity, discard word.
    - otherwise push word.
  - If both stop and parity are bad, only err_frame is set.
- RX FIFO:
  - Pop when rx_rd_en && !rx_empty; a pop while empty is ignored.
  - Push of a good word when full and no pop the same cycle: word dropped, err_overrun set.
  - Push and pop the same cycle while full: both succeed, level unchanged, no overrun.
  - rx_data updates the edge after a push into an empty FIFO or after a pop.
- Error flags:
  - err_clr clears all three on the next edge.
  - If a new error occurs in the same cycle as err_clr, the set wins.
- tx_level and rx_level are exact and range 0..FIFO_DEPTH.

Test Plan:
(All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4 unless stated.)
- Loopback tx→rx, PARITY=0: push 0xA5, 0x3C → tx line 0,1,0,1,0,0,1,0,1,1 per 4 cycles; rx_data shows 0xA5 then 0x3C after pops; no errors.
- TX full: 5 pushes of 0x01..0x05 with tx idle held by reset release timing → tx_full=1 after the 4th; 0x05 is never transmitted; tx_level=4.
- PARITY=2 (even), inject frame 0x07 with parity bit 0 → word discarded, err_parity=1, rx_empty=1. Then err_clr → 0.
- Inject 0x55 with stop bit 0 → err_frame=1, nothing pushed. A 1-cycle low glitch on rx → no rx_busy after the start sample, no flags.
- Overrun: receive 5 words without popping → rx_level=4, err_overrun=1, rx_data=first word. Rerun with rx_rd_en pulsed on the 5th push → level stays 4, err_overrun=0.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 → tx=1 next edge, tx_busy=0, levels 0. Repeat with DATA_BITS=9, STOP_BITS=2: 0x1FF transmitted in 12 bit times.
